// File: rtl/aes_stream_if_if.sv
// rtl/aes_stream_if_if.sv - byte stream, key and mode signals between a host and aes_stream_if
interface aes_stream_if_if;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key_in;
    logic         mode_in;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         out_ready;

    modport slave (
        input  in_byte, in_valid, key_in, mode_in, out_ready,
        output in_ready, out_byte, out_valid
    );

    modport master (
        output in_byte, in_valid, key_in, mode_in, out_ready,
        input  in_ready, out_byte, out_valid
    );
endinterface

// File: rtl/aes_stream_if.sv
// rtl/aes_stream_if.sv - byte-serial front/back end for the AES128 core; optional flush port under AES_STREAM_IF_FLUSH_EN
module aes_stream_if #(
    parameter int CORE_LATENCY   = 12,
    parameter int KEYEXP_LATENCY = 11,
    parameter int CNT_W          = 5
) (
    input  logic           clk,
    input  logic           reset,
`ifdef AES_STREAM_IF_FLUSH_EN
    input  logic           flush,
`endif
    aes_stream_if_if.slave strm,
    output logic [127:0]   core_msg,
    output logic [127:0]   core_key,
    output logic           core_sel,
    output logic           core_start,
    input  logic [127:0]   core_result,
    output logic           busy
);

    generate
        if (CORE_LATENCY < 1 || CORE_LATENCY + KEYEXP_LATENCY >= (1 << CNT_W)) begin : g_bad_cnt_w
            $error("aes_stream_if: CNT_W cannot hold CORE_LATENCY+KEYEXP_LATENCY");
        end
    endgenerate

    typedef enum logic [2:0] {LOAD, START, WAIT, CAPTURE, DRAIN} state_t;

    localparam logic [CNT_W-1:0] WAIT_HIT  = CNT_W'(CORE_LATENCY - 1);
    localparam logic [CNT_W-1:0] WAIT_MISS = CNT_W'(CORE_LATENCY + KEYEXP_LATENCY - 1);

    state_t             state_q, state_d;
    logic [3:0]         k_q, k_d, j_q, j_d;
    logic [127:0]       msg_q, msg_d, key_q, key_d, res_q, res_d, last_key_q, last_key_d;
    logic               sel_q, sel_d, key_valid_q, key_valid_d, flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_in;
    logic [7:0]         out_byte_c;

`ifdef AES_STREAM_IF_FLUSH_EN
    assign flush_in = flush;
`else
    assign flush_in = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LOAD;
            k_q          <= '0;
            j_q          <= '0;
            msg_q        <= '0;
            key_q        <= '0;
            sel_q        <= 1'b0;
            res_q        <= '0;
            last_key_q   <= '0;
            key_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            j_q          <= j_d;
            msg_q        <= msg_d;
            key_q        <= key_d;
            sel_q        <= sel_d;
            res_q        <= res_d;
            last_key_q   <= last_key_d;
            key_valid_q  <= key_valid_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        j_d          = j_q;
        msg_d        = msg_q;
        key_d        = key_q;
        sel_d        = sel_q;
        res_d        = res_q;
        last_key_d   = last_key_q;
        key_valid_d  = key_valid_q;
        flush_pend_d = flush_pend_q;
        cnt_d        = cnt_q;
        case (state_q)
            LOAD: begin
                if (flush_in) begin
                    k_d = '0;
                    j_d = '0;
                end else if (strm.in_valid) begin
                    // Byte 0 lands in the most significant byte (core bit 0 is the MSB)
                    for (int i = 0; i < 16; i++) begin
                        if (k_q == 4'(i)) msg_d[127-8*i -: 8] = strm.in_byte;
                    end
                    if (k_q == 4'd15) begin
                        k_d         = '0;
                        key_d       = strm.key_in;
                        sel_d       = strm.mode_in;
                        cnt_d       = (!key_valid_q || strm.key_in != last_key_q) ? WAIT_MISS : WAIT_HIT;
                        last_key_d  = strm.key_in;
                        key_valid_d = 1'b1;
                        state_d     = START;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            START: begin
                flush_pend_d = flush_pend_q | flush_in;
                state_d      = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    // A flush seen during the run only takes effect once the core is done
                    flush_pend_d = 1'b0;
                    state_d      = (flush_pend_q | flush_in) ? LOAD : CAPTURE;
                end else begin
                    flush_pend_d = flush_pend_q | flush_in;
                    cnt_d        = cnt_q - CNT_W'(1);
                end
            end
            CAPTURE: begin
                res_d   = core_result;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (flush_in) begin
                    j_d     = '0;
                    k_d     = '0;
                    state_d = LOAD;
                end else if (strm.out_ready) begin
                    if (j_q == 4'd15) begin
                        j_d     = '0;
                        k_d     = '0;
                        state_d = LOAD;
                    end else begin
                        j_d = j_q + 4'd1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        out_byte_c = '0;
        if (state_q == DRAIN) begin
            for (int i = 0; i < 16; i++) begin
                if (j_q == 4'(i)) out_byte_c = res_q[127-8*i -: 8];
            end
        end
    end

    assign strm.in_ready  = (state_q == LOAD) && !reset;
    assign strm.out_valid = (state_q == DRAIN);
    assign strm.out_byte  = out_byte_c;
    assign core_msg       = msg_q;
    assign core_key       = key_q;
    assign core_sel       = sel_q;
    assign core_start     = (state_q == START);
    assign busy           = (state_q != LOAD);

endmodule

// File: tb/tb_aes_stream_if.sv
// tb/tb_aes_stream_if.sv - table-driven scoreboard bench for aes_stream_if with a behavioural AES core stand-in
module tb_aes_stream_if;

    localparam logic [127:0] K   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] X   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic         mode;
        logic [127:0] exp;
        int           wait_cyc;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] core_msg, core_key, core_result;
    logic         core_sel, core_start, busy;
`ifdef AES_STREAM_IF_FLUSH_EN
    logic         flush;
`endif

    aes_stream_if_if sif();

    aes_stream_if dut (
        .clk         (clk),
        .reset       (reset),
`ifdef AES_STREAM_IF_FLUSH_EN
        .flush       (flush),
`endif
        .strm        (sif),
        .core_msg    (core_msg),
        .core_key    (core_key),
        .core_sel    (core_sel),
        .core_start  (core_start),
        .core_result (core_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errs   = 0;

    logic [7:0] exp_q[$];
    int         exp_first_q[$];
    int         exp_start_q[$];
    int         drained;
    int         stall_cnt;
    bit         stall_en;
    logic       prev_ov;
    vec_t       vt[6];

    // Core stand-in: known FIPS-197 pair, otherwise an arbitrary keyed mix
    function automatic logic [127:0] core_f(input logic [127:0] m, input logic [127:0] k, input logic s);
        if (s && k == K && m == PT) return CT;
        if (!s && k == K && m == CT) return PT;
        return {m[63:0], m[127:64]} ^ k ^ {128{s}};
    endfunction

    int           mdl_age, mdl_lat;
    logic         mdl_run, mdl_kv;
    logic [127:0] mdl_lastkey;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl_run     <= 1'b0;
            mdl_kv      <= 1'b0;
            mdl_age     <= 0;
            mdl_lat     <= 0;
            mdl_lastkey <= '0;
        end else if (core_start) begin
            mdl_lat     <= (!mdl_kv || core_key != mdl_lastkey) ? 23 : 12;
            mdl_lastkey <= core_key;
            mdl_kv      <= 1'b1;
            mdl_run     <= 1'b1;
            mdl_age     <= 1;
        end else if (mdl_run) begin
            mdl_age <= mdl_age + 1;
        end
    end

    assign core_result = (mdl_run && mdl_age >= mdl_lat) ? core_f(core_msg, core_key, core_sel)
                                                         : 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        drained   = 0;
        stall_cnt = 0;
        prev_ov   = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                exp_first_q.delete();
                exp_start_q.delete();
                drained       = 0;
                stall_cnt     = 0;
                prev_ov       = 1'b0;
                sif.out_ready = 1'b1;
            end else begin
                if (stall_en && sif.out_valid && drained == 3 && stall_cnt < 5) begin
                    sif.out_ready = 1'b0;
                    stall_cnt++;
                    if (exp_q.size() > 0) check("stall_hold_byte", 128'(sif.out_byte), 128'(exp_q[0]));
                end else begin
                    sif.out_ready = 1'b1;
                end
                if (sif.out_valid && !prev_ov) begin
                    if (exp_first_q.size() == 0) check("unexpected_out_valid", 128'(sif.out_valid), 128'(1'b0));
                    else check("first_out_valid_cycle", 128'(cyc), 128'(exp_first_q.pop_front()));
                end
                if (sif.out_valid && sif.out_ready) begin
                    if (exp_q.size() == 0) check("unexpected_out_byte", 128'(sif.out_valid), 128'(1'b0));
                    else check("out_byte", 128'(sif.out_byte), 128'(exp_q.pop_front()));
                    drained = (drained == 15) ? 0 : drained + 1;
                end
                if (core_start) begin
                    if (exp_start_q.size() == 0) check("unexpected_core_start", 128'(core_start), 128'(1'b0));
                    else check("core_start_cycle", 128'(cyc), 128'(exp_start_q.pop_front()));
                end
                if (sif.out_valid) check("in_ready_in_drain", 128'(sif.in_ready), 128'(1'b0));
                prev_ov = sif.out_valid;
            end
        end
    end

    task automatic send_block(input logic [127:0] blk, input logic [127:0] key, input logic mode,
                              input logic [127:0] exp, input int w, input bit want_out, output int t_last);
        int n;
        t_last = 0;
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            sif.in_byte  = blk[127-8*b -: 8];
            sif.in_valid = 1'b1;
            sif.key_in   = key;
            sif.mode_in  = mode;
            n = 0;
            while (!sif.in_ready && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) check("in_ready_timeout", 128'(sif.in_ready), 128'(1'b1));
            if (b == 15) begin
                t_last = cyc;
                exp_start_q.push_back(cyc + 1);
                if (want_out) begin
                    exp_first_q.push_back(cyc + 1 + w + 2);
                    for (int j = 0; j < 16; j++) exp_q.push_back(exp[127-8*j -: 8]);
                end
            end
        end
        @(negedge clk);
        sif.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_first_q.size() != 0 || exp_start_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("drain_timeout", 128'(exp_q.size() + exp_first_q.size() + exp_start_q.size()), 128'(0));
        @(negedge clk);
    endtask

    initial begin
        int t;
        int n;
        reset        = 1'b1;
        stall_en     = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_byte  = '0;
        sif.key_in   = '0;
        sif.mode_in  = 1'b0;
`ifdef AES_STREAM_IF_FLUSH_EN
        flush        = 1'b0;
`endif
        vt[0] = '{PT, K,  1'b1, CT, 23};
        vt[1] = '{PT, K,  1'b1, CT, 12};
        vt[2] = '{CT, K,  1'b0, PT, 12};
        vt[3] = '{X,  K2, 1'b1, core_f(X, K2, 1'b1), 23};
        vt[4] = '{X,  K2, 1'b0, core_f(X, K2, 1'b0), 12};
        vt[5] = '{PT, K,  1'b1, CT, 23};

        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready",  128'(sif.in_ready),  128'(1'b0));
        check("rst_out_valid", 128'(sif.out_valid), 128'(1'b0));
        check("rst_out_byte",  128'(sif.out_byte),  128'(0));
        check("rst_busy",      128'(busy),          128'(1'b0));
        check("rst_core_start",128'(core_start),    128'(1'b0));
        check("rst_core_msg",  core_msg,            128'(0));
        check("rst_core_key",  core_key,            128'(0));
        check("rst_core_sel",  128'(core_sel),      128'(1'b0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 128'(sif.in_ready), 128'(1'b1));
        check("post_rst_busy",     128'(busy),         128'(1'b0));

        for (int i = 0; i < 6; i++) begin
            send_block(vt[i].pt, vt[i].key, vt[i].mode, vt[i].exp, vt[i].wait_cyc, 1'b1, t);
            wait_drain();
        end

        // Backpressure on byte 3 with in_valid toggling while the block is in flight
        stall_en = 1'b1;
        send_block(PT, K, 1'b1, CT, 12, 1'b1, t);
        n = 0;
        while (exp_q.size() > 2 && n < 400) begin
            @(negedge clk);
            sif.in_valid = ~sif.in_valid;
            sif.in_byte  = 8'h5a;
            n++;
        end
        sif.in_valid = 1'b0;
        wait_drain();
        check("stall_cycles", 128'(stall_cnt), 128'(5));
        stall_en = 1'b0;

        // Asynchronous reset in the middle of WAIT
        send_block(PT, K, 1'b1, CT, 12, 1'b1, t);
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_busy",       128'(busy),          128'(1'b0));
        check("mid_rst_core_msg",   core_msg,            128'(0));
        check("mid_rst_core_key",   core_key,            128'(0));
        check("mid_rst_core_sel",   128'(core_sel),      128'(1'b0));
        check("mid_rst_core_start", 128'(core_start),    128'(1'b0));
        check("mid_rst_out_valid",  128'(sif.out_valid), 128'(1'b0));
        check("mid_rst_in_ready",   128'(sif.in_ready),  128'(1'b0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        send_block(PT, K, 1'b1, CT, 23, 1'b1, t);
        wait_drain();

`ifdef AES_STREAM_IF_FLUSH_EN
        // Flush after 7 input bytes, then a full block must still be assembled correctly
        for (int b = 0; b < 7; b++) begin
            @(negedge clk);
            sif.in_valid = 1'b1;
            sif.in_byte  = 8'(8'hc0 + b);
        end
        @(negedge clk);
        sif.in_valid = 1'b0;
        flush        = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        send_block(CT, K, 1'b0, PT, 12, 1'b1, t);
        wait_drain();

        // Flush during WAIT: no output, back to LOAD when the wait ends
        send_block(PT, K, 1'b1, CT, 12, 1'b0, t);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        while (cyc < t + 1 + 12) @(negedge clk);
        check("flush_wait_busy_end", 128'(busy), 128'(1'b1));
        @(negedge clk);
        check("flush_wait_back_to_load", 128'(busy), 128'(1'b0));
        repeat (5) @(negedge clk);
        send_block(PT, K, 1'b1, CT, 12, 1'b1, t);
        wait_drain();
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
